light: RTL and testbench
========================

// Module: light
// PURPOSE
//   Traffic-light LED driver: four RGB LEDs packed into a 12-bit bus.
//   Four colours come from a string parameter, decoded at elaboration.
//   A 2-bit mode select picks off, static palette, blinking caution or an
//   automatic red/green/yellow cycle. Sits between board switches and LEDs.
// PARAMETERS
//   C_COLOR     "100 010 110 111"  four RGB codes, entry0..3 left to right;
//                                  entry0=red, 1=green, 2=yellow, 3=walk
//   C_BLINK_CYC 50   clk cycles per blink half-period (>=1)
//   C_T_RED     100  AUTO red-phase length in clk cycles (>=1)
//   C_T_GREEN   100  AUTO green-phase length in clk cycles (>=1)
//   C_T_YELLOW  40   AUTO yellow-phase length in clk cycles (>=1)
// PORTS
//   clk     in   1   system clock; single clock domain
//   rstb    in   1   reset; synchronous, active-low
//   inSel   in   2   mode select; asynchronous to clk
//   outLED  out  12  LED k = outLED[3k+2:3k], bit order {R,G,B}
// BEHAVIOUR
// - C_COLOR decode: chars 4i..4i+2 (i=0 leftmost) form COLOR[i], first char
//   = R. Char '1' -> 1, any other char -> 0. Pure elaboration-time constants.
// - inSel passes a 2-FF synchronizer -> sSel. outLED is fully registered.
//   Latency from an inSel change to outLED: 3 clk edges.
// - Mode decoded from sSel:
//   00 OFF    : outLED = 0.
//   01 STATIC : LED k = COLOR[k], k=0..3 (default 12'hF94).
//   10 BLINK  : LEDs 0..3 = COLOR[2] in the ON phase, 0 in the OFF phase.
//               Phase toggles every C_BLINK_CYC cycles; ON on entry.
//   11 AUTO   : FSM RED -> GREEN -> YELLOW -> RED. LEDs 0..2 = COLOR of the
//               current state; LED3 = COLOR[3] in RED, 0 otherwise.
//               Each state lasts exactly its C_T_* cycles. A cycle counter
//               clears on each transition; the transition fires when
//               count == C_T_x-1. Default values: RED 12'hF24,
//               GREEN 12'h092, YELLOW 12'h1B6.
// - Mode change: detected when sSel differs from its previous value.
//   Blink counter/phase and AUTO FSM/counter reinit (phase ON, state RED,
//   count 0). The new mode's output appears on the next clk edge.
//   Re-entering AUTO always restarts at RED with a full C_T_RED.
// - Reset (rstb=0 at a clk edge, also mid-operation): synchronizer regs = 00
//   (mode OFF), outLED = 0, phase ON, FSM RED, all counters 0.
//   After release the output stays 0 until the synchronized inSel arrives.
// - Counters are sized clog2(max C_* + 1) and never wrap past their limit.
// - X/Z on inSel is not filtered; synchronizer handles metastability only.
// TESTING
// - rstb=0 for 20 cycles, inSel=01 -> outLED=0 throughout. Release ->
//   outLED=12'hF94 exactly 3 edges later.
// - inSel 01->00 -> outLED=0 after 3 edges. inSel 00->01 -> 12'hF94.
// - inSel=10, C_BLINK_CYC=50 -> 12'hDB6 for 50 cycles, 0 for 50 cycles,
//   repeating. Measure the period = 100 cycles.
// - inSel=11 -> 12'hF24 for 100 cycles, 12'h092 for 100, 12'h1B6 for 40,
//   then back to 12'hF24. Total loop = 240 cycles.
// - In AUTO during GREEN, pulse inSel 11->01->11 (each held >=3 cycles) ->
//   output returns to 12'hF24 with a full 100-cycle red phase.
// - Assert rstb=0 mid-AUTO and mid-BLINK -> outLED=0 on the next edge.
//   After release with inSel=11 -> sequence restarts at RED.

Source files
------------

// File: rtl/light.sv
// Traffic-light LED driver: four RGB LEDs on a 12-bit bus with off, static,
// blinking-caution and automatic red/green/yellow cycling modes.
module light #(
    parameter logic [8*15-1:0] C_COLOR     = "100 010 110 111",
    parameter int              C_BLINK_CYC = 50,
    parameter int              C_T_RED     = 100,
    parameter int              C_T_GREEN   = 100,
    parameter int              C_T_YELLOW  = 40
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [1:0]  inSel,
    output logic [11:0] outLED
);

    localparam int C_LEN = 15;

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Character 4*idx+b (leftmost = 0) supplies colour bit {R,G,B}[b]; only '1' lights.
    function automatic logic [2:0] color_f(input int idx);
        logic [2:0] rgb;
        logic [7:0] ch;
        rgb = 3'b000;
        for (int b = 0; b < 3; b++) begin
            ch          = C_COLOR[(C_LEN - 1 - (4 * idx + b)) * 8 +: 8];
            rgb[2 - b]  = (ch == 8'h31);
        end
        return rgb;
    endfunction

    localparam int C_MAX = max_f(max_f(C_BLINK_CYC, C_T_RED), max_f(C_T_GREEN, C_T_YELLOW));
    localparam int CW    = $clog2(C_MAX + 1);

    localparam logic [2:0] COL0 = color_f(0);
    localparam logic [2:0] COL1 = color_f(1);
    localparam logic [2:0] COL2 = color_f(2);
    localparam logic [2:0] COL3 = color_f(3);

    localparam logic [11:0] STATIC_LED = {COL3, COL2, COL1, COL0};
    localparam logic [11:0] BLINK_LED  = {COL2, COL2, COL2, COL2};
    localparam logic [11:0] RED_LED    = {COL3, COL0, COL0, COL0};
    localparam logic [11:0] GREEN_LED  = {3'b000, COL1, COL1, COL1};
    localparam logic [11:0] YELLOW_LED = {3'b000, COL2, COL2, COL2};

    localparam logic [CW-1:0] BLINK_LAST  = CW'(C_BLINK_CYC - 1);
    localparam logic [CW-1:0] RED_LAST    = CW'(C_T_RED - 1);
    localparam logic [CW-1:0] GREEN_LAST  = CW'(C_T_GREEN - 1);
    localparam logic [CW-1:0] YELLOW_LAST = CW'(C_T_YELLOW - 1);

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    ssel_q,  ssel_d;
    logic [1:0]    prev_q,  prev_d;
    logic          phase_q, phase_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [11:0]   out_q,   out_d;

    logic          mode_chg_s;
    logic          phase_e_s;
    state_t        state_e_s;
    logic [CW-1:0] cnt_e_s;
    logic [CW-1:0] last_s;

    // Next-state and output logic: synchronizer, blink phase and AUTO sequencer.
    always_comb begin
        sync1_d = inSel;
        ssel_d  = sync1_q;
        prev_d  = ssel_q;

        // A mode change restarts timing so the new mode begins at its first phase.
        mode_chg_s = (ssel_q != prev_q);
        phase_e_s  = mode_chg_s ? 1'b1 : phase_q;
        state_e_s  = mode_chg_s ? ST_RED : state_q;
        cnt_e_s    = mode_chg_s ? {CW{1'b0}} : cnt_q;

        phase_d = 1'b1;
        state_d = ST_RED;
        cnt_d   = {CW{1'b0}};
        out_d   = 12'h000;
        last_s  = RED_LAST;

        case (ssel_q)
            2'b00: begin
                out_d = 12'h000;
            end
            2'b01: begin
                out_d = STATIC_LED;
            end
            2'b10: begin
                out_d = phase_e_s ? BLINK_LED : 12'h000;
                if (cnt_e_s == BLINK_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    phase_d = ~phase_e_s;
                end else begin
                    cnt_d   = cnt_e_s + CW'(1);
                    phase_d = phase_e_s;
                end
            end
            2'b11: begin
                case (state_e_s)
                    ST_RED: begin
                        out_d   = RED_LED;
                        last_s  = RED_LAST;
                        state_d = ST_GREEN;
                    end
                    ST_GREEN: begin
                        out_d   = GREEN_LED;
                        last_s  = GREEN_LAST;
                        state_d = ST_YELLOW;
                    end
                    ST_YELLOW: begin
                        out_d   = YELLOW_LED;
                        last_s  = YELLOW_LAST;
                        state_d = ST_RED;
                    end
                    default: begin
                        out_d   = RED_LED;
                        last_s  = RED_LAST;
                        state_d = ST_RED;
                    end
                endcase
                if (cnt_e_s == last_s) begin
                    cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d   = cnt_e_s + CW'(1);
                    state_d = state_e_s;
                end
            end
            default: begin
                out_d = 12'h000;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            sync1_q <= 2'b00;
            ssel_q  <= 2'b00;
            prev_q  <= 2'b00;
            phase_q <= 1'b1;
            state_q <= ST_RED;
            cnt_q   <= {CW{1'b0}};
            out_q   <= 12'h000;
        end else begin
            sync1_q <= sync1_d;
            ssel_q  <= ssel_d;
            prev_q  <= prev_d;
            phase_q <= phase_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign outLED = out_q;

endmodule

// File: tb/tb_light.sv
// Scoreboard bench for light: stimulus queues one expected outLED per clock
// edge; a negedge monitor pops and compares.
module tb_light;

    logic        clk = 1'b0;
    logic        rstb;
    logic [1:0]  inSel;
    logic [11:0] outLED;

    light dut (
        .clk    (clk),
        .rstb   (rstb),
        .inSel  (inSel),
        .outLED (outLED)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] val;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [11:0] OFF_V    = 12'h000;
    localparam logic [11:0] STATIC_V = 12'hF94;
    localparam logic [11:0] BLINK_V  = 12'hDB6;
    localparam logic [11:0] RED_V    = 12'hF24;
    localparam logic [11:0] GREEN_V  = 12'h092;
    localparam logic [11:0] YELLOW_V = 12'h1B6;

    // Queue the expected output for each of the next n clock edges.
    task automatic step(input int n, input logic [11:0] v, input string tag);
        exp_t e;
        e.val = v;
        e.tag = tag;
        repeat (n) begin
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (outLED !== e.val) begin
                    bad++;
                    $display("FAIL %s: outLED=%h expected=%h at t=%0t", e.tag, outLED, e.val, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rstb  = 1'b0;
        inSel = 2'b01;
        step(20, OFF_V, "reset_hold");
        rstb = 1'b1;
        step(2, OFF_V, "release_latency");
        step(10, STATIC_V, "static_after_reset");

        inSel = 2'b00;
        step(2, STATIC_V, "off_latency");
        step(10, OFF_V, "off");
        inSel = 2'b01;
        step(2, OFF_V, "static_latency");
        step(10, STATIC_V, "static");

        inSel = 2'b10;
        step(2, STATIC_V, "blink_latency");
        for (int i = 0; i < 2; i++) begin
            step(50, BLINK_V, "blink_on");
            step(50, OFF_V, "blink_off");
        end
        step(10, BLINK_V, "blink_on_again");

        rstb = 1'b0;
        step(5, OFF_V, "reset_mid_blink");
        rstb  = 1'b1;
        inSel = 2'b11;
        step(2, OFF_V, "auto_latency");
        step(100, RED_V, "auto_red");
        step(100, GREEN_V, "auto_green");
        step(40, YELLOW_V, "auto_yellow");
        step(100, RED_V, "auto_red_loop");
        step(30, GREEN_V, "auto_green_loop");

        inSel = 2'b01;
        step(2, GREEN_V, "pulse_latency");
        step(1, STATIC_V, "pulse_static");
        inSel = 2'b11;
        step(2, STATIC_V, "reenter_latency");
        step(100, RED_V, "reenter_full_red");
        step(5, GREEN_V, "reenter_green");

        rstb = 1'b0;
        step(3, OFF_V, "reset_mid_auto");
        rstb = 1'b1;
        step(2, OFF_V, "auto_release_latency");
        step(100, RED_V, "restart_red");
        step(2, GREEN_V, "restart_green");

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
